// File: rtl/fpga_serial_rx.sv
// fpga_serial_rx: synchronized 9-bit serial frame receiver with parity check, 16x4 table and good-frame counter
module fpga_serial_rx #(
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_clk,
  input  logic       ser_frame,
  input  logic       ser_data,
  output logic [3:0] rx_addr,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [7:0] frame_cnt
);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, frm_s, dat_s, rdy;
  logic clk_d, frm_d, wait_low;
  logic [3:0] bit_cnt;
  logic [8:0] sr;
  logic [3:0] mem [16];
  logic edge_det, rise, good, start, shift_en, len_err, check_ok, check_bad;
  assign edge_det = clk_s[1] & ~clk_d;
  assign rise = frm_s[1] & ~frm_d;
  assign good = (^sr) == PARITY_ODD;
  always_comb begin
    state_n = state;
    start = 1'b0;
    shift_en = 1'b0;
    len_err = 1'b0;
    check_ok = 1'b0;
    check_bad = 1'b0;
    case (state)
      IDLE: begin
        start = rise && !wait_low;
        state_n = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        len_err = bit_cnt != 4'd9 && !frm_s[1];
        shift_en = bit_cnt != 4'd9 && frm_s[1] && edge_det;
        state_n = bit_cnt == 4'd9 ? CHECK : len_err ? IDLE : SHIFT;
      end
      CHECK: begin
        check_ok = good;
        check_bad = !good;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // wait_low starts set so a frame already in flight at reset release is skipped;
  // rdy holds it until the synchronizers carry real ser_frame values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      clk_s <= '0;
      frm_s <= '0;
      dat_s <= '0;
      rdy <= '0;
      clk_d <= 1'b0;
      frm_d <= 1'b0;
      wait_low <= 1'b1;
      bit_cnt <= '0;
      sr <= '0;
      rx_addr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
      frame_cnt <= '0;
      rd_data <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      clk_s <= {clk_s[0], ser_clk};
      frm_s <= {frm_s[0], ser_frame};
      dat_s <= {dat_s[0], ser_data};
      rdy <= {rdy[0], 1'b1};
      clk_d <= clk_s[1];
      frm_d <= frm_s[1];
      if (state == CHECK) wait_low <= frm_s[1];
      else if (rdy[1] && !frm_s[1]) wait_low <= 1'b0;
      if (start) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) sr <= {sr[7:0], dat_s[1]};
      rx_valid <= check_ok;
      rx_err <= check_bad | len_err;
      if (check_ok) begin
        rx_addr <= sr[8:5];
        rx_data <= sr[4:1];
        mem[sr[8:5]] <= sr[4:1];
      end
      if (check_ok && frame_cnt != 8'hff) frame_cnt <= frame_cnt + 8'd1;
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: doc/fpga_serial_rx.md
FPGA_SERIAL_RX -- requirements
Module: fpga_serial_rx

Interface
REQ-001 SHALL have parameter PARITY_ODD, default 1, meaning: 1 = odd parity over the 8 payload bits, 0 = even parity.
REQ-002 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port ser_clk, input, 1 bit: transmitter bit clock, asynchronous to clk.
REQ-005 SHALL have port ser_frame, input, 1 bit: frame envelope, high for the duration of a frame.
REQ-006 SHALL have port ser_data, input, 1 bit: serial data, stable around the ser_clk rising edge.
REQ-007 SHALL have port rx_addr, output, 4 bits: address field of the last good frame.
REQ-008 SHALL have port rx_data, output, 4 bits: data field of the last good frame.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-clk pulse per good frame.
REQ-010 SHALL have port rx_err, output, 1 bit: one-clk pulse per bad frame (parity or length).
REQ-011 SHALL have port rd_addr, input, 4 bits: read address into the received-data table.
REQ-012 SHALL have port rd_data, output, 4 bits: registered table contents at rd_addr.
REQ-013 SHALL have port frame_cnt, output, 8 bits: count of good frames, saturating.

Function
REQ-014 SHALL pass ser_clk, ser_frame and ser_data each through a 2-flop synchronizer on clk before any use.
REQ-015 SHALL detect a bit edge as synced ser_clk = 1 with its previous synced value = 0, and sample synced ser_data only in that cycle.
REQ-016 SHALL use the frame format, MSB-first: addr[3:0], then data[3:0], then one parity bit, for 9 bits total.
REQ-017 SHALL implement a state machine with states IDLE, SHIFT and CHECK.
REQ-018 SHALL, in IDLE, go to SHIFT and clear the bit counter on the synced ser_frame rising edge; edges in IDLE SHALL be ignored.
REQ-019 SHALL, in SHIFT, shift one bit per detected edge into a 9-bit register and increment the 4-bit bit counter.
REQ-020 SHALL, in SHIFT, go to CHECK in the cycle after the 9th bit is sampled.
REQ-021 SHALL, in SHIFT, treat synced ser_frame falling before 9 bits as a length error: pulse rx_err in the next cycle, then return to IDLE.
REQ-022 SHALL, in CHECK, compute parity across all 9 bits; the frame is good when XOR = 1 if PARITY_ODD = 1, or XOR = 0 if PARITY_ODD = 0.
REQ-023 SHALL, for a good frame in CHECK, update rx_addr/rx_data, pulse rx_valid, write the table at rx_addr, and increment frame_cnt, all in the same cycle.
REQ-024 SHALL, for a bad frame in CHECK, pulse rx_err and leave rx_addr, rx_data, the table and frame_cnt unchanged.
REQ-025 SHALL leave CHECK after exactly 1 cycle: to IDLE if synced ser_frame is low, otherwise to a wait-for-frame-low condition within IDLE.
REQ-026 SHALL ignore edges beyond bit 9 while ser_frame remains high; a new frame SHALL need a fresh ser_frame rising edge.
REQ-027 SHALL hold frame_cnt at 255 once it reaches 255.
REQ-028 SHALL never assert rx_valid and rx_err in the same cycle.
REQ-029 SHALL drive rd_data one clk after rd_addr.
REQ-030 SHALL, when a read and a write hit the same address in the same cycle, return the old value that cycle and the new value on the next.

Reset
REQ-031 SHALL, when rst_n = 0, immediately force: state IDLE, bit counter 0, shift register 0, synchronizers 0, rx_addr 0, rx_data 0, rx_valid 0, rx_err 0, frame_cnt 0, all 16 table entries 0, rd_data 0.
REQ-032 SHALL, on reset asserted mid-frame, discard the partial frame with no rx_valid or rx_err pulse.
REQ-033 SHALL, after reset release while ser_frame is high, wait for that frame to end and a new rising edge before receiving.

Verification
REQ-034 SHALL cover: frame addr=4'h3, data=4'hA, parity 1 (odd) -> exactly one rx_valid, rx_addr=3, rx_data=A, frame_cnt=1, rd_addr=3 gives rd_data=A.
REQ-035 SHALL cover: same frame with parity bit inverted -> one rx_err pulse, no rx_valid, frame_cnt unchanged, table entry 3 unchanged.
REQ-036 SHALL cover: ser_frame dropped after 5 bits -> one rx_err pulse, next complete frame addr=F, data=1 received correctly.
REQ-037 SHALL cover: rst_n pulsed low after bit 4 of a frame -> all outputs 0, no pulses, next frame received correctly.
REQ-038 SHALL cover: 260 back-to-back good frames -> frame_cnt stops at 255, last frame's data appears in the table.
REQ-039 SHALL cover: 12 ser_clk edges inside one ser_frame window -> exactly one rx_valid from the first 9 bits, extra edges ignored.
